// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NCH channels.
// Latency: req->ack 1 cycle from IDLE; out_valid the cycle after conv_done is seen in WAIT.
// Backpressure: requesters hold req until ack; requests arriving while busy wait for IDLE.
module bcd_conv_sched #(
  parameter int NCH     = 4,
  parameter int DW      = 14,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 63,
  parameter int MAXVAL  = 9999
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] data_bus,
  output logic [NCH-1:0]    ack,
  output logic              conv_enable,
  output logic [DW-1:0]     conv_data,
  input  logic              conv_done,
  input  logic [3:0]        conv_tho,
  input  logic [3:0]        conv_hun,
  input  logic [3:0]        conv_ten,
  input  logic [3:0]        conv_uni,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [15:0]       out_bcd,
  output logic              out_ovf,
  output logic              busy,
  output logic              timeout_err
);

  // Counter covers both the 2-cycle guard and the WAIT timeout window.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GUARD,
    WAIT,
    CAPTURE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   cur_ch;
  logic              ovf_pend;
  logic [CW-1:0]     cnt;

  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W:0]     scan_c;
  logic [DW-1:0]     sel_val;
  logic [DW-1:0]     chval [NCH];

  logic              do_grant;
  logic              do_capture;
  logic              do_timeout;

  // Split the flat data bus into one value per channel.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign chval[i] = data_bus[i*DW +: DW];
  end

  assign sel_val     = chval[gnt_idx];
  assign conv_enable = (state == START);
  assign busy        = (state != IDLE);

  // Round-robin scan: highest offset first so the nearest requester at/after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan_c  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      scan_c = {1'b0, ptr} + (CH_W+1)'(k);
      if (scan_c >= (CH_W+1)'(NCH)) begin
        scan_c = scan_c - (CH_W+1)'(NCH);
      end
      if (req[scan_c[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_c[CH_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          do_grant  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = GUARD;
      end
      GUARD: begin
        // conv_done still reflects the previous conversion here; ignore it.
        if (cnt == CW'(1)) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (conv_done) begin
          do_capture = 1'b1;
          state_nxt  = CAPTURE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cycle counter: zero on every state entry, counts only in GUARD and WAIT.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == GUARD || state == WAIT) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Datapath: grant capture with clamp, result registration, sticky timeout flag.
  // Digits are registered on the edge where done is seen, so out_valid and the
  // digits appear together during the CAPTURE cycle.
  always_ff @(posedge clkin) begin
    if (reset) begin
      ack         <= '0;
      conv_data   <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_bcd     <= '0;
      out_ovf     <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cur_ch      <= '0;
      ovf_pend    <= 1'b0;
    end else begin
      ack       <= '0;
      out_valid <= 1'b0;
      if (do_grant) begin
        ack    <= NCH'(1) << gnt_idx;
        cur_ch <= gnt_idx;
        ptr    <= (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        if (sel_val > DW'(MAXVAL)) begin
          conv_data <= DW'(MAXVAL);
          ovf_pend  <= 1'b1;
        end else begin
          conv_data <= sel_val;
          ovf_pend  <= 1'b0;
        end
      end
      if (do_capture) begin
        out_valid <= 1'b1;
        out_bcd   <= {conv_tho, conv_hun, conv_ten, conv_uni};
        out_ch    <= cur_ch;
        out_ovf   <= ovf_pend;
      end
      if (do_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
